// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the data port and the shared memory bus.
// The arbiter takes the slave side; requesters and memory sit on master.
interface mem_arbiter_if;
    logic [31:0] ibus_address;
    logic        ibus_rd;
    logic [31:0] ibus_rdata;
    logic        ibus_stall;

    logic [31:0] dbus_address;
    logic [31:0] dbus_wdata;
    logic        dbus_rd;
    logic        dbus_wr;
    logic [3:0]  dbus_byte_en;
    logic [31:0] dbus_rdata;
    logic        dbus_stall;

    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  ibus_address, ibus_rd,
        output ibus_rdata, ibus_stall,
        input  dbus_address, dbus_wdata, dbus_rd, dbus_wr, dbus_byte_en,
        output dbus_rdata, dbus_stall,
        output mem_address, mem_wdata, mem_rd, mem_wr, mem_byte_en,
        input  mem_rdata, mem_ack
    );

    modport master (
        output ibus_address, ibus_rd,
        input  ibus_rdata, ibus_stall,
        output dbus_address, dbus_wdata, dbus_rd, dbus_wr, dbus_byte_en,
        input  dbus_rdata, dbus_stall,
        input  mem_address, mem_wdata, mem_rd, mem_wr, mem_byte_en,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory bus between fetch and load/store.
// Data port wins ties; a completed port yields to the other before re-grant.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        D_BUSY,
        D_DONE,
        I_BUSY,
        I_DONE
    } state_t;

    state_t      state_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_wdata_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic [3:0]  mem_byte_en_q;
    logic [31:0] ibus_rdata_q;
    logic [31:0] dbus_rdata_q;

    logic d_req;
    assign d_req = bus.dbus_rd | bus.dbus_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_byte_en_q <= '0;
            ibus_rdata_q  <= '0;
            dbus_rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE, I_DONE: begin
                    if (d_req) begin
                        // a store wins if both strobes are raised
                        state_q       <= D_BUSY;
                        mem_address_q <= bus.dbus_address;
                        mem_wdata_q   <= bus.dbus_wdata;
                        mem_byte_en_q <= bus.dbus_byte_en;
                        mem_wr_q      <= bus.dbus_wr;
                        mem_rd_q      <= ~bus.dbus_wr;
                    end else if (bus.ibus_rd && state_q == IDLE) begin
                        state_q       <= I_BUSY;
                        mem_address_q <= bus.ibus_address;
                        mem_wdata_q   <= '0;
                        mem_byte_en_q <= 4'b1111;
                        mem_wr_q      <= 1'b0;
                        mem_rd_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                D_DONE: begin
                    if (bus.ibus_rd) begin
                        state_q       <= I_BUSY;
                        mem_address_q <= bus.ibus_address;
                        mem_wdata_q   <= '0;
                        mem_byte_en_q <= 4'b1111;
                        mem_wr_q      <= 1'b0;
                        mem_rd_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                D_BUSY, I_BUSY: begin
                    if (bus.mem_ack) begin
                        if (state_q == I_BUSY) begin
                            ibus_rdata_q <= bus.mem_rdata;
                        end else if (mem_rd_q) begin
                            dbus_rdata_q <= bus.mem_rdata;
                        end
                        state_q       <= (state_q == I_BUSY) ? I_DONE : D_DONE;
                        mem_address_q <= '0;
                        mem_wdata_q   <= '0;
                        mem_byte_en_q <= '0;
                        mem_rd_q      <= 1'b0;
                        mem_wr_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_byte_en = mem_byte_en_q;
    assign bus.ibus_rdata  = ibus_rdata_q;
    assign bus.dbus_rdata  = dbus_rdata_q;
    assign bus.dbus_stall  = d_req & (state_q != D_DONE);
    assign bus.ibus_stall  = bus.ibus_rd & (state_q != I_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of the fetch/data arbiter plus an alternating
// back-to-back run with random memory acknowledge.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mem_zero(input string tag);
        check({tag, "_addr"}, bus.mem_address, 32'h0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_be"}, {28'h0, bus.mem_byte_en}, 32'h0);
        check({tag, "_rd"}, {31'h0, bus.mem_rd}, 32'h0);
        check({tag, "_wr"}, {31'h0, bus.mem_wr}, 32'h0);
    endtask

    logic [31:0] sent;
    logic        exp_d;
    logic        d_low;
    logic        i_low;
    logic        prev_low;
    int          done;
    int          cyc;

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst = 1'b1;
        bus.ibus_address = '0;
        bus.ibus_rd      = 1'b0;
        bus.dbus_address = '0;
        bus.dbus_wdata   = '0;
        bus.dbus_rd      = 1'b0;
        bus.dbus_wr      = 1'b0;
        bus.dbus_byte_en = '0;
        bus.mem_rdata    = '0;
        bus.mem_ack      = 1'b0;

        // reset state
        tick;
        tick;
        mem_zero("rst");
        check("rst_irdata", bus.ibus_rdata, 32'h0);
        check("rst_drdata", bus.dbus_rdata, 32'h0);
        bus.ibus_rd = 1'b1;
        #1;
        check("rst_istall", {31'h0, bus.ibus_stall}, 32'h1);
        bus.ibus_rd = 1'b0;
        rst = 1'b0;

        // fetch only, ack tied high
        bus.ibus_rd      = 1'b1;
        bus.ibus_address = 32'h0000_0100;
        bus.mem_ack      = 1'b1;
        bus.mem_rdata    = 32'h2402_0005;
        #1;
        check("f_c0_stall", {31'h0, bus.ibus_stall}, 32'h1);
        tick;
        check("f_c1_rd", {31'h0, bus.mem_rd}, 32'h1);
        check("f_c1_addr", bus.mem_address, 32'h100);
        check("f_c1_be", {28'h0, bus.mem_byte_en}, 32'hF);
        check("f_c1_stall", {31'h0, bus.ibus_stall}, 32'h1);
        tick;
        check("f_c2_stall", {31'h0, bus.ibus_stall}, 32'h0);
        check("f_c2_rdata", bus.ibus_rdata, 32'h2402_0005);
        mem_zero("f_c2");
        bus.ibus_rd = 1'b0;
        tick;

        // simultaneous: data first, then fetch straight from D_DONE
        bus.ibus_rd      = 1'b1;
        bus.ibus_address = 32'h0000_0104;
        bus.dbus_rd      = 1'b1;
        bus.dbus_address = 32'h8000_0004;
        bus.dbus_byte_en = 4'b1111;
        bus.mem_rdata    = 32'h1111_2222;
        tick;
        check("s_c1_addr", bus.mem_address, 32'h8000_0004);
        check("s_c1_rd", {31'h0, bus.mem_rd}, 32'h1);
        check("s_c1_dstall", {31'h0, bus.dbus_stall}, 32'h1);
        tick;
        check("s_c2_dstall", {31'h0, bus.dbus_stall}, 32'h0);
        check("s_c2_drdata", bus.dbus_rdata, 32'h1111_2222);
        check("s_c2_istall", {31'h0, bus.ibus_stall}, 32'h1);
        bus.dbus_rd   = 1'b0;
        bus.mem_rdata = 32'h3333_4444;
        tick;
        check("s_c3_addr", bus.mem_address, 32'h104);
        check("s_c3_rd", {31'h0, bus.mem_rd}, 32'h1);
        tick;
        check("s_c4_istall", {31'h0, bus.ibus_stall}, 32'h0);
        check("s_c4_irdata", bus.ibus_rdata, 32'h3333_4444);
        bus.ibus_rd = 1'b0;
        tick;

        // store with three wait states; inputs change while busy
        bus.dbus_wr      = 1'b1;
        bus.dbus_address = 32'h0000_0200;
        bus.dbus_byte_en = 4'b0010;
        bus.dbus_wdata   = 32'hABAB_ABAB;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = 32'h7777_7777;
        tick;
        bus.dbus_wdata   = 32'hDEAD_BEEF;
        bus.dbus_address = 32'h0000_0999;
        bus.dbus_byte_en = 4'b1000;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("st_c%0d_wr", c), {31'h0, bus.mem_wr}, 32'h1);
            check($sformatf("st_c%0d_be", c), {28'h0, bus.mem_byte_en}, 32'h2);
            check($sformatf("st_c%0d_wd", c), bus.mem_wdata, 32'hABAB_ABAB);
            check($sformatf("st_c%0d_ad", c), bus.mem_address, 32'h200);
            check($sformatf("st_c%0d_st", c), {31'h0, bus.dbus_stall}, 32'h1);
            if (c == 4) bus.mem_ack = 1'b1;
            tick;
        end
        check("st_c5_stall", {31'h0, bus.dbus_stall}, 32'h0);
        check("st_c5_drdata", bus.dbus_rdata, 32'h1111_2222);
        mem_zero("st_c5");
        bus.dbus_wr = 1'b0;
        bus.mem_ack = 1'b0;
        tick;

        // both strobes: write wins
        bus.dbus_rd      = 1'b1;
        bus.dbus_wr      = 1'b1;
        bus.dbus_address = 32'h0000_0300;
        bus.dbus_wdata   = 32'h5A5A_5A5A;
        bus.dbus_byte_en = 4'b1111;
        tick;
        check("rw_wr", {31'h0, bus.mem_wr}, 32'h1);
        check("rw_rd", {31'h0, bus.mem_rd}, 32'h0);
        check("rw_wdata", bus.mem_wdata, 32'h5A5A_5A5A);

        // asynchronous reset in D_BUSY, then re-grant
        rst = 1'b1;
        #1;
        mem_zero("ar");
        check("ar_irdata", bus.ibus_rdata, 32'h0);
        check("ar_dstall", {31'h0, bus.dbus_stall}, 32'h1);
        rst = 1'b0;
        tick;
        check("ar_regrant_wr", {31'h0, bus.mem_wr}, 32'h1);
        check("ar_regrant_ad", bus.mem_address, 32'h300);
        bus.mem_ack = 1'b1;
        tick;
        check("ar_done_stall", {31'h0, bus.dbus_stall}, 32'h0);
        check("ar_done_drdata", bus.dbus_rdata, 32'h0);
        bus.dbus_rd = 1'b0;
        bus.dbus_wr = 1'b0;
        tick;

        // ack while idle is ignored
        bus.mem_rdata = 32'hCAFE_F00D;
        tick;
        mem_zero("idle_ack");
        check("idle_ack_drdata", bus.dbus_rdata, 32'h0);

        // back-to-back alternating traffic with random ack
        bus.dbus_rd      = 1'b1;
        bus.ibus_rd      = 1'b1;
        bus.dbus_address = 32'h8000_0000;
        bus.ibus_address = 32'h0000_1000;
        exp_d    = 1'b1;
        prev_low = 1'b0;
        done     = 0;
        cyc      = 0;
        while (done < 100 && cyc < 2000) begin
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            sent = bus.mem_rdata;
            tick;
            cyc++;
            d_low = ~bus.dbus_stall;
            i_low = ~bus.ibus_stall;
            if (d_low || i_low) begin
                check("b2b_dport", {31'h0, d_low}, {31'h0, exp_d});
                check("b2b_iport", {31'h0, i_low}, {31'h0, ~exp_d});
                check("b2b_rdata", exp_d ? bus.dbus_rdata : bus.ibus_rdata, sent);
                check("b2b_toggle", {31'h0, prev_low}, 32'h0);
                exp_d = ~exp_d;
                done++;
                bus.dbus_address = bus.dbus_address + 32'h4;
                bus.ibus_address = bus.ibus_address + 32'h4;
            end
            prev_low = d_low | i_low;
        end
        check("b2b_count", done, 32'd100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
